// File: rtl/fnn_pkg.sv
// rtl/fnn_pkg.sv - shared types and sizing helpers for the layer serializer
package fnn_pkg;

   typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_t;

   localparam int DATA_WIDTH = 16;

   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/layer_gather_bank.sv
// rtl/layer_gather_bank.sv - per-neuron capture slots, filled bitmap, overrun flag
module layer_gather_bank
   import fnn_pkg::*;
#(
   parameter int numNeurons = 30,
   parameter int dataWidth  = DATA_WIDTH
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [numNeurons*dataWidth-1:0] in_data,
   input  logic [numNeurons-1:0]           in_valid,
   input  logic                            transfer,
   output logic [numNeurons*dataWidth-1:0] bank,
   output logic                            complete,
   output logic                            overrun
);

   logic [numNeurons-1:0] filled;
   logic [numNeurons-1:0] accept;

   // On a transfer edge the bank is being emptied, so every arriving slot is fresh.
   always_comb begin
      accept = transfer ? in_valid : (in_valid & ~filled);
   end

   assign complete = &filled;

   always_ff @(posedge clk) begin
      if (rst) begin
         filled  <= '0;
         overrun <= 1'b0;
      end else begin
         filled <= (transfer ? '0 : filled) | in_valid;
         if (!transfer && |(in_valid & filled))
            overrun <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < numNeurons; i++) begin
         if (accept[i])
            bank[i*dataWidth +: dataWidth] <= in_data[i*dataWidth +: dataWidth];
      end
   end

endmodule

// File: rtl/layer_out_serializer.sv
// rtl/layer_out_serializer.sv - gathers one layer's neuron outputs and streams them in slot order
module layer_out_serializer
   import fnn_pkg::*;
#(
   parameter int numNeurons = 30,
   parameter int dataWidth  = DATA_WIDTH
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [numNeurons*dataWidth-1:0] in_data,
   input  logic [numNeurons-1:0]           in_valid,
   output logic [dataWidth-1:0]            out_data,
   output logic                            out_valid,
   output logic                            out_last,
   output logic                            busy,
   output logic                            overrun
);

   localparam int            CW   = clog2_min1(numNeurons);
   localparam logic [CW-1:0] LAST = CW'(numNeurons - 1);

   ser_state_t                      state;
   logic [CW-1:0]                   count;
   logic [numNeurons*dataWidth-1:0] shreg;
   logic [numNeurons*dataWidth-1:0] bank;
   logic                            complete;
   logic                            transfer;

   // A new set is taken either from idle or on the final beat, so streams chain without a bubble.
   assign transfer = complete && (state == SER_IDLE || count == LAST);

   layer_gather_bank #(
      .numNeurons (numNeurons),
      .dataWidth  (dataWidth)
   ) u_bank (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data),
      .in_valid (in_valid),
      .transfer (transfer),
      .bank     (bank),
      .complete (complete),
      .overrun  (overrun)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= SER_IDLE;
         count     <= '0;
         shreg     <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
      end else if (transfer) begin
         state     <= SER_SHIFT;
         busy      <= 1'b1;
         count     <= '0;
         out_valid <= 1'b1;
         out_data  <= bank[dataWidth-1:0];
         shreg     <= bank >> dataWidth;
         out_last  <= (LAST == '0);
      end else if (state == SER_SHIFT && count != LAST) begin
         count     <= count + CW'(1);
         out_data  <= shreg[dataWidth-1:0];
         shreg     <= shreg >> dataWidth;
         out_last  <= ((count + CW'(1)) == LAST);
      end else begin
         state     <= SER_IDLE;
         busy      <= 1'b0;
         count     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_layer_out_serializer.sv
// tb/tb_layer_out_serializer.sv - scoreboard bench for a 4-neuron and a 1-neuron serializer
module tb_layer_out_serializer;

   typedef struct {
      logic [15:0] data;
      logic        last;
      int          edge_no;
   } beat_t;

   logic        clk;
   logic        rst4, rst1;
   logic [63:0] in_data4;
   logic [3:0]  in_valid4;
   logic [15:0] in_data1;
   logic [0:0]  in_valid1;
   logic [15:0] out_data4, out_data1;
   logic        out_valid4, out_last4, busy4, overrun4;
   logic        out_valid1, out_last1, busy1, overrun1;

   int    checks = 0;
   int    errors = 0;
   int    edge_cnt = 0;
   bit    mon_en = 0;
   beat_t q0[$];
   beat_t q1[$];

   bit [3:0]    m_filled [2];
   logic [15:0] m_val    [2][4];
   int          m_free   [2];
   bit          m_ovr    [2];

   layer_out_serializer #(.numNeurons(4), .dataWidth(16)) dut4 (
      .clk(clk), .rst(rst4), .in_data(in_data4), .in_valid(in_valid4),
      .out_data(out_data4), .out_valid(out_valid4), .out_last(out_last4),
      .busy(busy4), .overrun(overrun4));

   layer_out_serializer #(.numNeurons(1), .dataWidth(16)) dut1 (
      .clk(clk), .rst(rst1), .in_data(in_data1), .in_valid(in_valid1),
      .out_data(out_data1), .out_valid(out_valid1), .out_last(out_last1),
      .busy(busy1), .overrun(overrun1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d edge %0d: got %h expected %h", name, d, edge_cnt, act, exp);
      end
   endtask

   // Reference: a full set transfers at the first edge after it completes once the previous
   // stream has had its N beats; transfer beat k appears after edge T+k.
   task automatic model_edge(input int d, input bit r, input logic [3:0] v, input logic [63:0] data);
      int       n    = (d == 0) ? 4 : 1;
      bit [3:0] mask = (d == 0) ? 4'hF : 4'h1;
      beat_t    b;
      if (r) begin
         m_filled[d] = '0;
         m_free[d]   = 0;
         m_ovr[d]    = 0;
         if (d == 0) q0.delete(); else q1.delete();
         return;
      end
      if (m_filled[d] == mask && edge_cnt >= m_free[d]) begin
         for (int k = 0; k < n; k++) begin
            b.data    = m_val[d][k];
            b.last    = (k == n - 1);
            b.edge_no = edge_cnt + k;
            if (d == 0) q0.push_back(b); else q1.push_back(b);
         end
         m_filled[d] = '0;
         m_free[d]   = edge_cnt + n;
      end
      for (int i = 0; i < n; i++) begin
         if (v[i]) begin
            if (m_filled[d][i]) m_ovr[d] = 1;
            else begin
               m_val[d][i]    = data[i*16 +: 16];
               m_filled[d][i] = 1'b1;
            end
         end
      end
   endtask

   task automatic cycle(input bit r4, input logic [3:0] v4, input logic [63:0] d4,
                        input bit r1, input logic v1, input logic [15:0] d1);
      @(negedge clk);
      rst4 = r4; in_valid4 = v4; in_data4 = d4;
      rst1 = r1; in_valid1 = v1; in_data1 = d1;
      @(posedge clk);
      edge_cnt++;
      model_edge(0, r4, v4, d4);
      model_edge(1, r1, {3'b000, v1}, {48'h0, d1});
   endtask

   task automatic idle4(input int n);
      for (int i = 0; i < n; i++) cycle(0, 4'h0, 64'h0, 0, 1'b0, 16'h0);
   endtask

   task automatic mon(input int d, input logic ov, input logic [15:0] od, input logic ol,
                      input logic bz, input logic orun);
      beat_t b;
      bit    have = 0;
      bit    exp_v;
      if (d == 0) begin
         if (q0.size() > 0 && q0[0].edge_no <= edge_cnt) begin b = q0.pop_front(); have = 1; end
      end else begin
         if (q1.size() > 0 && q1[0].edge_no <= edge_cnt) begin b = q1.pop_front(); have = 1; end
      end
      if (have && b.edge_no != edge_cnt) begin
         checks++; errors++;
         $display("FAIL missed_beat dut%0d edge %0d: beat due at edge %0d not seen", d, edge_cnt, b.edge_no);
      end
      exp_v = have && (b.edge_no == edge_cnt);
      chk("out_valid", d, {31'b0, ov}, {31'b0, exp_v});
      chk("busy", d, {31'b0, bz}, {31'b0, exp_v});
      chk("out_data", d, {16'b0, od}, exp_v ? {16'b0, b.data} : 32'h0);
      chk("out_last", d, {31'b0, ol}, exp_v ? {31'b0, b.last} : 32'h0);
      chk("overrun", d, {31'b0, orun}, {31'b0, m_ovr[d]});
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         mon(0, out_valid4, out_data4, out_last4, busy4, overrun4);
         mon(1, out_valid1, out_data1, out_last1, busy1, overrun1);
      end
   end

   initial begin
      int wait_cnt;
      rst4 = 1; rst1 = 1; in_valid4 = '0; in_data4 = '0; in_valid1 = '0; in_data1 = '0;
      cycle(1, 4'h0, 64'h0, 1, 1'b0, 16'h0);
      mon_en = 1;
      cycle(1, 4'h0, 64'h0, 1, 1'b0, 16'h0);
      idle4(2);

      // all slots at once
      cycle(0, 4'hF, 64'h8000_FFFF_0002_0001, 0, 1'b0, 16'h0);
      idle4(7);

      // staggered arrival
      cycle(0, 4'b0101, 64'h0000_0C0C_0000_0A0A, 0, 1'b0, 16'h0);
      idle4(4);
      cycle(0, 4'b1000, 64'h0D0D_0000_0000_0000, 0, 1'b0, 16'h0);
      idle4(3);
      cycle(0, 4'b0010, 64'h0000_0000_0B0B_0000, 0, 1'b0, 16'h0);
      idle4(8);

      // back-to-back sets, second one landing on the transfer edge
      cycle(0, 4'hF, 64'h1004_1003_1002_1001, 0, 1'b0, 16'h0);
      cycle(0, 4'hF, 64'h2004_2003_2002_2001, 0, 1'b0, 16'h0);
      idle4(12);

      // overrun on slot 1
      cycle(0, 4'b0010, 64'h0000_0000_1111_0000, 0, 1'b0, 16'h0);
      cycle(0, 4'b0010, 64'h0000_0000_2222_0000, 0, 1'b0, 16'h0);
      cycle(0, 4'b1101, 64'h3333_4444_0000_5555, 0, 1'b0, 16'h0);
      idle4(7);
      cycle(1, 4'h0, 64'h0, 0, 1'b0, 16'h0);
      idle4(2);

      // reset mid-stream on beat 2
      cycle(0, 4'hF, 64'hA004_A003_A002_A001, 0, 1'b0, 16'h0);
      idle4(2);
      cycle(1, 4'h0, 64'h0, 0, 1'b0, 16'h0);
      idle4(2);
      cycle(0, 4'hF, 64'hB004_B003_B002_B001, 0, 1'b0, 16'h0);
      idle4(7);

      // single-neuron layer
      cycle(0, 4'h0, 64'h0, 0, 1'b1, 16'h7FFF);
      idle4(4);

      // randomized traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         logic [3:0]  v4;
         logic [63:0] d4;
         for (int b = 0; b < 4; b++) v4[b] = ($urandom_range(0, 2) == 0);
         d4 = {$urandom, $urandom};
         cycle(($urandom_range(0, 79) == 0), v4, d4,
               ($urandom_range(0, 79) == 0), ($urandom_range(0, 3) == 0), 16'($urandom));
      end

      wait_cnt = 0;
      while ((q0.size() > 0 || q1.size() > 0) && wait_cnt < 50) begin
         idle4(1);
         wait_cnt++;
      end
      idle4(2);
      checks++;
      if (q0.size() > 0 || q1.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d and %0d beats still expected, required 0", q0.size(), q1.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/layer_out_serializer.md
Name: layer_out_serializer

Overview:
Sits directly downstream of one layer's neuron array (e.g. the 30 layer-1 neurons) and upstream of the next layer.
- Collects each neuron's `out` value as its `outvalid` pulses into a gather bank.
- Once every slot is filled, transfers the bank to a shift register.
- Streams the values one per cycle, neuron 0 first, as the next layer's `myinput`/`myinputValid` stream.
- The next layer has no backpressure, so the stream is never stalled.

Parameters:
- numNeurons, 30, number of neurons in the producing layer (>=1).
- dataWidth, 16, width of one neuron output and of the output stream.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  numNeurons*dataWidth  concatenated neuron outputs; slot i = bits [i*dataWidth +: dataWidth].
- in_valid  input  numNeurons  per-neuron `outvalid`; bit i qualifies slot i.
- out_data  output  dataWidth  serialized value (feeds next layer's `myinput`).
- out_valid  output  1  stream qualifier (feeds next layer's `myinputValid`).
- out_last  output  1  high with the final beat (neuron numNeurons-1).
- busy  output  1  high while state is SHIFT.
- overrun  output  1  sticky error flag; cleared only by rst.

Behaviour:
- Reset: all of the following are 0 from the edge where rst=1:
  - outputs out_data, out_valid, out_last, busy, overrun;
  - gather bitmap, shift counter;
  - state = IDLE.
- Reset mid-stream aborts the stream: no further beats, partial gathers discarded.
- Gather bank: numNeurons x dataWidth registers plus a numNeurons-bit filled bitmap.
  - At an edge with in_valid[i]=1 and filled[i]=0: store slot i, set filled[i].
  - Bits may arrive in any cycle and in any order; all-at-once is the normal case.
- Overrun: in_valid[i]=1 while filled[i]=1 and no transfer at that edge → new value dropped, stored value kept, overrun set.
- complete = filled is all ones (registered; evaluated the edge after the last slot is stored).
- State machine, states IDLE and SHIFT:
  - IDLE → SHIFT when complete=1.
    - Load shift register from the bank, clear filled, count=0.
  - SHIFT: each cycle drive element[count] with out_valid=1; count increments each edge.
    - At count=numNeurons-1: out_last=1.
    - Next edge: if complete=1, reload and stay in SHIFT with count=0 (back-to-back, no bubble); else → IDLE.
- Simultaneous events: at a transfer edge, an in_valid[i] arriving for any slot is written into the freshly cleared bank and sets filled[i]. This is not an overrun.
- Latency: last slot sampled at edge E → transfer at edge E+1 → beat 0 visible in the cycle after E+1 → last beat numNeurons-1 cycles later.
- Outputs:
  - out_data is registered from the shift register and is 0 whenever out_valid=0.
  - busy equals (state==SHIFT).
- Widths: count width is $clog2(numNeurons); use 1 when numNeurons=1. With numNeurons=1, every SHIFT beat is also the last.
- No arithmetic on data: values pass bit-exact (signed fixed-point as produced by the neuron).

Decomposition:
- Shared package fnn_pkg:
  - state enum ser_state_t {SER_IDLE, SER_SHIFT};
  - localparam DATA_WIDTH=16;
  - function clog2_min1 for counter sizing.
- One sub-module is natural: layer_gather_bank. It holds the bitmap, the slot registers, overrun detection and `complete`. The top level keeps the FSM and the shift register.

Test Plan:
1. numNeurons=4; all in_valid=4'b1111 at edge E with values 0x0001,0x0002,0xFFFF,0x8000 → out_valid high for 4 cycles starting cycle after E+1. out_data 0x0001,0x0002,0xFFFF,0x8000; out_last on 4th beat; busy high for those 4 cycles; overrun stays 0.
2. Staggered arrival: in_valid bits 0,2 at cycle 0, bit 3 at cycle 5, bit 1 at cycle 9 → no out_valid before the cycle after edge 10. Stream order is still slot 0..3 with the captured values.
3. Back-to-back: second full set of in_valid arrives at the edge where beat 0 of the first stream is loaded → 8 consecutive valid beats, no gap. out_last on beats 4 and 8.
4. Overrun: slot 1 written 0x1111, slot 1 pulsed again with 0x2222 before the set completes → overrun=1 sticky. Streamed slot 1 = 0x1111. After rst, overrun=0.
5. Reset mid-stream: rst at beat 2 of 4 → out_valid/out_last/busy=0 the cycle after the rst edge. A subsequent full set streams cleanly from slot 0.
6. numNeurons=1: single in_valid pulse with 0x7FFF → exactly one beat with out_valid=1, out_last=1, out_data=0x7FFF.
